bht_counter_table: RTL and testbench
====================================

// Module: bht_counter_table
// PURPOSE
// - Branch history table: 2-bit saturating-counter direction predictor, lookup from frontend, trained by branch resolution.
// - Consumes the resolved-branch record produced by the execute-stage branch unit (valid, pc, is_taken, cf_type==Branch).
// - One lookup and one update per cycle; table cleared by a sequential sweep after reset or flush.
// PARAMETERS
// - NR_ENTRIES  1024  table depth, power of two, >=4
// - VLEN        riscv::VLEN  virtual address width
// PORTS
// - clk_i             in   1     clock
// - rst_i             in   1     synchronous reset, active-high
// - flush_i           in   1     invalidate whole table (restart sweep)
// - debug_mode_i      in   1     1: training updates dropped
// - vpc_i             in   VLEN  lookup PC (frontend)
// - pred_valid_o      out  1     entry valid, prediction usable
// - pred_taken_o      out  1     predicted taken (counter MSB)
// - ready_o           out  1     sweep done, table operational
// - upd_valid_i       in   1     resolved branch valid
// - upd_pc_i          in   VLEN  PC of resolved branch
// - upd_is_branch_i   in   1     cf_type==Branch; only these train
// - upd_taken_i       in   1     actual outcome
// - upd_mispredict_i  in   1     resolved as mispredict (stats only)
// BEHAVIOUR
// - Index = pc[$clog2(NR_ENTRIES):1] (halfword granule, compressed-aware); no tags.
// - Entry = {valid, cnt[1:0]}. Lookup combinational from array: pred_valid_o=valid&ready_o, pred_taken_o=cnt[1]&pred_valid_o.
// - FSM SWEEP -> READY. rst_i: state=SWEEP, sweep_idx=0, update stage cleared, ready_o=0, pred_* =0.
// - SWEEP: writes entry[sweep_idx]={0,2'b01}, sweep_idx++ each cycle; after idx NR_ENTRIES-1 -> READY next cycle (NR_ENTRIES cycles total, wrap not allowed).
// - SWEEP: updates dropped (not queued), lookups return pred_valid_o=0.
// - READY + flush_i: -> SWEEP, sweep_idx=0, pending update stage discarded. flush_i during SWEEP restarts at 0. rst_i has priority over flush_i.
// - Update accept (cycle N): upd_valid_i & upd_is_branch_i & ~debug_mode_i & ready_o & ~flush_i -> register {idx,taken}.
// - Cycle N+1: read entry[idx], write new value at end of N+1; visible to lookup from cycle N+2.
// - New value: invalid entry -> {1, taken?2'b10:2'b01}; valid: taken -> cnt+1 saturating at 3; not taken -> cnt-1 saturating at 0.
// - Back-to-back updates same index (N, N+1): second reads array already holding first result; no forwarding needed, no lost update.
// - Lookup and write same index same cycle: lookup returns old value.
// - Non-branch cf_types (JumpR, Return, Jump, NoCF) never train.
// CONFIGURATION
// - BHT_STATS_EN defined: adds outputs stat_upd_cnt_o[31:0], stat_mispred_cnt_o[31:0]; increment on each accepted update / accepted update with upd_mispredict_i; wrap at 2^32; cleared by rst_i only (not flush_i).
// - BHT_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
// - ariane_pkg: bht_entry_t {valid, cnt[1:0]}, bht_update_t {valid, pc, taken}, function bht_sat_next(entry, taken).
// - Single module; array as flops (no SRAM macro); no sub-module.
// TESTING
// - rst_i 1 cycle, NR_ENTRIES=16 -> ready_o=0 for 16 cycles, 1 on 17th; pred_valid_o=0 throughout.
// - Update pc=0x80000004 taken x3, then lookup -> cnt 2,3,3; pred_taken_o=1, valid=1, visible 2 cycles after each update.
// - Update pc=0x80000008 not-taken x2 from cnt=3 back-to-back -> cnt=1, pred_taken_o=0; no lost update.
// - Update with upd_is_branch_i=0 or debug_mode_i=1 -> entry unchanged; stats unchanged.
// - flush_i mid-update in READY, then flush_i again at sweep_idx=5 -> pending update discarded, sweep restarts at 0, all entries invalid after.
// - BHT_STATS_EN: 10 accepted updates, 3 with mispredict, 1 dropped in SWEEP -> stat_upd_cnt_o=10, stat_mispred_cnt_o=3.

Source files
------------

// File: rtl/bht_counter_table_pkg.sv
// Shared types for the branch history table: table entry, registered update
// record, sweep/ready FSM encoding and the 2-bit saturating counter step.
package bht_counter_table_pkg;

  // Virtual address width used by the update record.
  localparam int unsigned VLEN = 64;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_READY = 1'b1
  } bht_state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] cnt;
  } bht_entry_t;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_update_t;

  // An invalid entry is seeded weakly toward the first outcome. A valid entry
  // moves one step toward the outcome and saturates at 0 and 3.
  function automatic bht_entry_t bht_sat_next(input bht_entry_t entry, input logic taken);
    bht_entry_t next;
    next.valid = 1'b1;
    if (!entry.valid) begin
      next.cnt = taken ? 2'b10 : 2'b01;
    end else if (taken) begin
      next.cnt = (entry.cnt == 2'b11) ? 2'b11 : entry.cnt + 2'b01;
    end else begin
      next.cnt = (entry.cnt == 2'b00) ? 2'b00 : entry.cnt - 2'b01;
    end
    return next;
  endfunction

endpackage

// File: rtl/bht_counter_table.sv
// Branch history table: tagless 2-bit saturating counters indexed by the
// halfword PC. Lookup is combinational; training is a two-stage
// register-then-read-modify-write. After reset or flush the table is cleared
// by a one-entry-per-cycle sweep before it reports ready.
// Optional build macro: BHT_STATS_EN adds accepted-update/mispredict counters.
//
// Update handshake: an update is taken in the cycle where upd_valid_i and
// upd_is_branch_i are high, debug_mode_i and flush_i are low and ready_o is
// high. There is no backpressure; updates offered while not ready are dropped.
module bht_counter_table
  import bht_counter_table_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 1024,
  parameter int unsigned VLEN       = bht_counter_table_pkg::VLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            debug_mode_i,
  input  logic [VLEN-1:0] vpc_i,
  output logic            pred_valid_o,
  output logic            pred_taken_o,
  output logic            ready_o,
  input  logic            upd_valid_i,
  input  logic [VLEN-1:0] upd_pc_i,
  input  logic            upd_is_branch_i,
  input  logic            upd_taken_i,
  input  logic            upd_mispredict_i,
`ifdef BHT_STATS_EN
  output logic [31:0]     stat_upd_cnt_o,
  output logic [31:0]     stat_mispred_cnt_o,
`endif
  output bht_state_e      state_o
);

  localparam int unsigned IDX_W = $clog2(NR_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);

  bht_state_e       state_q, state_d;
  logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
  logic             sweep_we;
  bht_update_t      upd_q;
  bht_entry_t       table_q [NR_ENTRIES];

  logic             upd_accept;
  logic             upd_we;
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] lookup_idx;
  bht_entry_t       lookup_entry;

  assign ready_o = (state_q == ST_READY);
  assign state_o = state_q;

  assign upd_accept = upd_valid_i & upd_is_branch_i & ~debug_mode_i & ready_o & ~flush_i;
  // A flush or reset in the write cycle discards the pending update.
  assign upd_we     = upd_q.valid & ready_o & ~flush_i & ~rst_i;
  assign upd_idx    = upd_q.pc[IDX_W:1];

  assign lookup_idx   = vpc_i[IDX_W:1];
  assign lookup_entry = table_q[lookup_idx];
  assign pred_valid_o = lookup_entry.valid & ready_o;
  assign pred_taken_o = lookup_entry.cnt[1] & pred_valid_o;

  // Sweep/ready sequencing: walk every index once, flush restarts at zero.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    sweep_we    = 1'b0;
    case (state_q)
      ST_SWEEP: begin
        sweep_we = 1'b1;
        if (flush_i) begin
          sweep_idx_d = '0;
        end else if (sweep_idx_q == LAST_IDX) begin
          sweep_idx_d = '0;
          state_d     = ST_READY;
        end else begin
          sweep_idx_d = sweep_idx_q + 1'b1;
        end
      end
      ST_READY: begin
        if (flush_i) begin
          state_d     = ST_SWEEP;
          sweep_idx_d = '0;
        end
      end
      default: begin
        state_d     = ST_SWEEP;
        sweep_idx_d = '0;
      end
    endcase
  end

  // FSM state, sweep pointer and the registered update record.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_SWEEP;
      sweep_idx_q <= '0;
      upd_q       <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      upd_q.valid <= upd_accept;
      upd_q.pc    <= bht_counter_table_pkg::VLEN'(upd_pc_i);
      upd_q.taken <= upd_taken_i;
    end
  end

  // Counter array: sweep clears, otherwise the registered update is applied.
  always_ff @(posedge clk_i) begin
    if (sweep_we) begin
      table_q[sweep_idx_q] <= '{valid: 1'b0, cnt: 2'b01};
    end else if (upd_we) begin
      table_q[upd_idx] <= bht_sat_next(table_q[upd_idx], upd_q.taken);
    end
  end

`ifdef BHT_STATS_EN
  // Free-running statistics; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_upd_cnt_o     <= '0;
      stat_mispred_cnt_o <= '0;
    end else if (upd_accept) begin
      stat_upd_cnt_o <= stat_upd_cnt_o + 32'd1;
      if (upd_mispredict_i) begin
        stat_mispred_cnt_o <= stat_mispred_cnt_o + 32'd1;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{vpc_i[VLEN-1:IDX_W+1], vpc_i[0],
                         upd_q.pc[bht_counter_table_pkg::VLEN-1:IDX_W+1], upd_q.pc[0]};
`else
  logic unused_bits;
  assign unused_bits = ^{vpc_i[VLEN-1:IDX_W+1], vpc_i[0], upd_mispredict_i,
                         upd_q.pc[bht_counter_table_pkg::VLEN-1:IDX_W+1], upd_q.pc[0]};
`endif

endmodule

// File: tb/tb_bht_counter_table.sv
// Bench for bht_counter_table with a 16-entry table: reset sweep timing,
// training/saturation, update visibility latency, back-to-back updates,
// filtered updates, flush/restart and (when built with BHT_STATS_EN) stats.
module tb_bht_counter_table;
  import bht_counter_table_pkg::*;

  localparam int unsigned NR = 16;
  localparam int unsigned VW = 64;

  logic          clk;
  logic          rst_i;
  logic          flush_i;
  logic          debug_mode_i;
  logic [VW-1:0] vpc_i;
  logic          pred_valid_o;
  logic          pred_taken_o;
  logic          ready_o;
  logic          upd_valid_i;
  logic [VW-1:0] upd_pc_i;
  logic          upd_is_branch_i;
  logic          upd_taken_i;
  logic          upd_mispredict_i;
  bht_state_e    state_o;
`ifdef BHT_STATS_EN
  logic [31:0]   stat_upd_cnt_o;
  logic [31:0]   stat_mispred_cnt_o;
`endif

  bht_counter_table #(
    .NR_ENTRIES (NR),
    .VLEN       (VW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .debug_mode_i     (debug_mode_i),
    .vpc_i            (vpc_i),
    .pred_valid_o     (pred_valid_o),
    .pred_taken_o     (pred_taken_o),
    .ready_o          (ready_o),
    .upd_valid_i      (upd_valid_i),
    .upd_pc_i         (upd_pc_i),
    .upd_is_branch_i  (upd_is_branch_i),
    .upd_taken_i      (upd_taken_i),
    .upd_mispredict_i (upd_mispredict_i),
`ifdef BHT_STATS_EN
    .stat_upd_cnt_o     (stat_upd_cnt_o),
    .stat_mispred_cnt_o (stat_mispred_cnt_o),
`endif
    .state_o          (state_o)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // Scoreboard: expected {pred_valid, pred_taken} per lookup
  logic [1:0] exp_q[$];

  // Reference model of the table contents
  logic       m_valid [NR];
  logic [1:0] m_cnt   [NR];
  int unsigned exp_upd = 0;
  int unsigned exp_mis = 0;

  function automatic int unsigned idx_of(input logic [VW-1:0] pc);
    return int'(pc[4:1]);
  endfunction

  function automatic logic [1:0] exp_of(input logic [VW-1:0] pc);
    int unsigned i;
    i = idx_of(pc);
    return {m_valid[i], m_valid[i] & m_cnt[i][1]};
  endfunction

  function automatic void model_train(input logic [VW-1:0] pc, input logic taken);
    int unsigned i;
    i = idx_of(pc);
    if (!m_valid[i]) begin
      m_valid[i] = 1'b1;
      m_cnt[i]   = taken ? 2'd2 : 2'd1;
    end else if (taken) begin
      if (m_cnt[i] != 2'd3) m_cnt[i] = m_cnt[i] + 2'd1;
    end else begin
      if (m_cnt[i] != 2'd0) m_cnt[i] = m_cnt[i] - 2'd1;
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NR; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 2'd1;
    end
  endfunction

  // Driver tasks (called at posedge+1, return at posedge+1)
  task automatic lookup(input logic [VW-1:0] pc, input string name);
    logic [1:0] got;
    logic [1:0] e;
    vpc_i = pc;
    exp_q.push_back(exp_of(pc));
    @(negedge clk);
    got = {pred_valid_o, pred_taken_o};
    e   = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s pc=%h got valid/taken=%b expected=%b", name, pc, got, e);
    end
    @(posedge clk); #1;
  endtask

  // One update, then a lookup in the next cycle (old value) and the one after (new).
  task automatic train(input logic [VW-1:0] pc, input logic taken, input logic mis,
                       input logic is_br, input logic dbg, input string name);
    logic acc;
    acc              = is_br & ~dbg;
    upd_valid_i      = 1'b1;
    upd_pc_i         = pc;
    upd_taken_i      = taken;
    upd_mispredict_i = mis;
    upd_is_branch_i  = is_br;
    debug_mode_i     = dbg;
    @(posedge clk); #1;
    upd_valid_i  = 1'b0;
    debug_mode_i = 1'b0;
    lookup(pc, {name, "_old"});
    if (acc) begin
      model_train(pc, taken);
      exp_upd++;
      if (mis) exp_mis++;
    end
    lookup(pc, {name, "_new"});
  endtask

  // Checks the sweep after a reset/flush edge just passed; optionally offers
  // an update in the final sweep cycle, which must be dropped.
  task automatic wait_sweep(input logic drop_upd, input string name);
    for (int i = 0; i < NR; i++) begin
      vpc_i = VW'($urandom_range(0, 255));
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b0 || pred_valid_o !== 1'b0 || pred_taken_o !== 1'b0) begin
        failures++;
        $display("FAIL %s_busy cycle=%0d ready=%b pred=%b%b expected 0", name, i + 1,
                 ready_o, pred_valid_o, pred_taken_o);
      end
      if (drop_upd && i == NR - 1) begin
        upd_valid_i      = 1'b1;
        upd_pc_i         = 64'h8000_0000;
        upd_is_branch_i  = 1'b1;
        upd_taken_i      = 1'b1;
        upd_mispredict_i = 1'b1;
      end
    end
    @(negedge clk);
    upd_valid_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || state_o !== ST_READY) begin
      failures++;
      $display("FAIL %s_ready cycle=%0d ready=%b state=%0d expected ready=1", name, NR + 1,
               ready_o, state_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    model_clear();
    wait_sweep(1'b0, "reset_sweep");
    lookup(64'h8000_0004, "reset_entry_a");
    lookup(64'h8000_001e, "reset_entry_b");
  endtask

  task automatic test_train_taken();
    for (int k = 0; k < 3; k++) train(64'h8000_0004, 1'b1, 1'b0, 1'b1, 1'b0, "taken_x3");
    // one not-taken step from a saturated 3 must leave it predicting taken
    train(64'h8000_0004, 1'b0, 1'b1, 1'b1, 1'b0, "sat_high_step");
  endtask

  task automatic test_back_to_back();
    train(64'h8000_0008, 1'b1, 1'b0, 1'b1, 1'b0, "b2b_prep");
    train(64'h8000_0008, 1'b1, 1'b0, 1'b1, 1'b0, "b2b_prep");
    // two not-taken updates in consecutive cycles: 3 -> 2 -> 1
    upd_valid_i = 1'b1; upd_is_branch_i = 1'b1; upd_pc_i = 64'h8000_0008;
    upd_taken_i = 1'b0; upd_mispredict_i = 1'b1;
    @(posedge clk); #1;
    upd_mispredict_i = 1'b0;
    @(posedge clk); #1;
    upd_valid_i = 1'b0;
    model_train(64'h8000_0008, 1'b0);
    exp_upd += 2; exp_mis += 1;
    lookup(64'h8000_0008, "b2b_first");
    model_train(64'h8000_0008, 1'b0);
    lookup(64'h8000_0008, "b2b_second");
    // and two more down to 0, then a taken step must reach 1 (not-taken)
    train(64'h8000_0008, 1'b0, 1'b0, 1'b1, 1'b0, "sat_low");
    train(64'h8000_0008, 1'b0, 1'b0, 1'b1, 1'b0, "sat_low_hold");
    train(64'h8000_0008, 1'b1, 1'b0, 1'b1, 1'b0, "sat_low_up");
  endtask

  task automatic test_filtered();
    train(64'h8000_0010, 1'b1, 1'b1, 1'b0, 1'b0, "non_branch");
    train(64'h8000_0010, 1'b1, 1'b1, 1'b1, 1'b1, "debug_mode");
    train(64'h8000_0004, 1'b0, 1'b1, 1'b0, 1'b0, "non_branch_valid");
  endtask

  task automatic test_flush();
    // accepted in cycle N, flushed in N+1 before the write lands
    upd_valid_i = 1'b1; upd_is_branch_i = 1'b1; upd_pc_i = 64'h8000_0006;
    upd_taken_i = 1'b1; upd_mispredict_i = 1'b0;
    exp_upd++;
    @(posedge clk); #1;
    upd_valid_i = 1'b0;
    flush_i     = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    // sweep_idx is 0 in this cycle; advance to sweep_idx 5 and flush again
    repeat (5) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    model_clear();
    wait_sweep(1'b1, "flush_sweep");
    lookup(64'h8000_0006, "flush_discard");
    lookup(64'h8000_0000, "sweep_drop");
    lookup(64'h8000_0004, "flush_clear_a");
    lookup(64'h8000_0008, "flush_clear_b");
    train(64'h8000_0006, 1'b0, 1'b1, 1'b1, 1'b0, "post_flush");
  endtask

  task automatic test_random();
    logic [VW-1:0] pc;
    for (int k = 0; k < 16; k++) begin
      pc = 64'h8000_0000 | VW'($urandom_range(0, 3) * 2);
      train(pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0), "random");
    end
  endtask

  task automatic test_stats();
`ifdef BHT_STATS_EN
    checks++;
    if (stat_upd_cnt_o !== exp_upd) begin
      failures++;
      $display("FAIL stat_upd got=%0d expected=%0d", stat_upd_cnt_o, exp_upd);
    end
    checks++;
    if (stat_mispred_cnt_o !== exp_mis) begin
      failures++;
      $display("FAIL stat_mispred got=%0d expected=%0d", stat_mispred_cnt_o, exp_mis);
    end
`endif
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; debug_mode_i = 1'b0; vpc_i = '0;
    upd_valid_i = 1'b0; upd_pc_i = '0; upd_is_branch_i = 1'b0;
    upd_taken_i = 1'b0; upd_mispredict_i = 1'b0;
    model_clear();
    test_reset();
    test_train_taken();
    test_back_to_back();
    test_filtered();
    test_flush();
    test_random();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
